sd_cmd_engine: RTL and testbench
================================

# sd_cmd_engine

Parametrised single-clock SD command-line engine. It serialises a 48-bit host command with an on-the-fly CRC7, then optionally captures and checks a short (48-bit) or long (136-bit) card response. It also supervises response timeout and enforces the inter-command gap. It sits between the host-controller sequencer and the CMD pad, and provides a bit-rate tick that the pad-side SD clock generator uses.

## Interface
- CLK_DIV, 2: clk cycles per SD bit period (≥2).
- NCR_MAX, 64: max bit periods waited for a response start bit.
- NCC_MIN, 8: idle bit periods enforced after each transaction before ready returns.
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- send_en  in  1  request; accepted only in a cycle where ready=1.
- cmd_index  in  6  command index, sampled at accept.
- cmd_arg  in  32  argument, sampled at accept.
- resp_type  in  2  sampled at accept: 00 none, 01 short+CRC (R1/R6/R7), 10 short no CRC (R3), 11 long (R2).
- sd_cmd_i  in  1  CMD line input.
- ready  out  1  engine idle and gap satisfied.
- sd_cmd_o  out  1  CMD line output bit.
- sd_cmd_oe  out  1  CMD output enable.
- bit_tick  out  1  one-cycle pulse on the last clk of each bit period while busy.
- resp  out  136  raw response incl. start/end bits; short in [47:0], [135:48]=0.
- done  out  1  one-cycle pulse at transaction end.
- timeout  out  1  sticky: no start bit within NCR_MAX.
- crc_err  out  1  sticky: CRC mismatch, transmission bit ≠0, or end bit ≠1.

## Operation
- States: IDLE → TX → (WAIT_RESP → RX) → GAP → IDLE.
- IDLE: ready=1. On send_en, latch index/arg/type, clear resp/timeout/crc_err, reset the divider, go to TX. send_en while ready=0 is ignored.
- TX: the frame is {0,1,cmd_index,cmd_arg,crc7,1}, sent MSB first. CRC7 (poly x⁷+x³+1, init 0) is updated serially over bits 47..8 as they shift. The 7 CRC bits then shift from the CRC register. No precomputation pass.
- After the end bit: resp_type=00 → done, go to GAP. Otherwise oe=0 and go to WAIT_RESP.
- WAIT_RESP: ignore the first 2 bit periods (NCR min). Sample sd_cmd_i at each bit_tick. The first 0 goes to RX. If NCR_MAX periods elapse with no start bit → timeout=1, done, go to GAP.
- RX: shift in the remaining 47 (short) or 135 (long) bits at bit_tick. The serial CRC7 covers resp bits [47:8] for 01 only.
- Checks at last bit: the end bit must be 1 for all types. Bit [46] (or [134] for long) must be 0. For 01, the CRC field [7:1] must equal the computed value. Any failure → crc_err=1. Then done, go to GAP.
- GAP: NCC_MIN bit periods with oe=0, then IDLE.

## Timing
- Accept at cycle 0. Start bit is driven from cycle 1 (oe=1, o=0). Bit k is held for cycles 1+k·CLK_DIV … (k+1)·CLK_DIV.
- oe falls at cycle 1+48·CLK_DIV.
- resp_type=00: done pulses at cycle 1+48·CLK_DIV. ready returns NCC_MIN·CLK_DIV cycles later.
- Response: done pulses the cycle after the last response bit is sampled. resp, timeout and crc_err are valid at done and hold until the next accept.
- Reset values: ready=1, sd_cmd_o=1, sd_cmd_oe=0, bit_tick=0, done=0, timeout=0, crc_err=0, resp=0, state IDLE.
- Reset mid-transaction: all of the above take effect immediately (async). No done pulse is produced.
- Divider width = clog2(CLK_DIV). Counters saturate/wrap only at their defined terminal counts.
- send_en held high across GAP is accepted on the first cycle ready=1.

## Test plan
- CMD0, arg 0, type 00, CLK_DIV=2 → CMD serial 0x400000000095; oe high for 96 cycles; done at cycle 97; ready at cycle 113.
- CMD8, arg 0x1AA, type 01, card replies 0x08000001AA13 after 4 periods → CMD tx 0x48000001AA87; resp[47:0]=0x08000001AA13; crc_err=0, timeout=0.
- Same as above but reply ends 0x...AA01 → crc_err=1, done pulses once.
- CMD17, arg 0, type 01, line held high → tx 0x510000000055; timeout=1 after 64 bit periods; resp=0.
- CMD2, type 11, 136-bit reply with end bit forced 0 → resp[135:0] equals the injected pattern; crc_err=1.
- Reset asserted mid-TX at bit 20 → oe=0, o=1, ready=1 in the same cycle; send_en pulses during TX/GAP are ignored.

Source files
------------

// File: rtl/sd_cmd_engine_if.sv
// Host-side and CMD-pad-side signals of the SD command engine.
// slave is the engine's view; master is the host/pad side used by a driver or bench.
interface sd_cmd_engine_if;
  logic         send_en;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         ready;
  logic         done;
  logic [135:0] resp;
  logic         timeout;
  logic         crc_err;
  logic         sd_cmd_i;
  logic         sd_cmd_o;
  logic         sd_cmd_oe;
  logic         bit_tick;

  modport slave (
    input  send_en, cmd_index, cmd_arg, resp_type, sd_cmd_i,
    output ready, done, resp, timeout, crc_err, sd_cmd_o, sd_cmd_oe, bit_tick
  );

  modport master (
    output send_en, cmd_index, cmd_arg, resp_type, sd_cmd_i,
    input  ready, done, resp, timeout, crc_err, sd_cmd_o, sd_cmd_oe, bit_tick
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: serialises a 48-bit command with on-the-fly CRC7, then captures
// and checks an optional short/long response, with NCR timeout and NCC gap enforcement.
module sd_cmd_engine #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned NCR_MAX = 64,
  parameter int unsigned NCC_MIN = 8
) (
  input logic           clk,
  input logic           reset,
  sd_cmd_engine_if.slave bus
);

  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntMax0 = (NCR_MAX > 135) ? NCR_MAX : 135;
  localparam int unsigned CntMax  = (NCC_MIN > CntMax0) ? NCC_MIN : CntMax0;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StTx, StWait, StRx, StGap} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [39:0]     tx_sr_q, tx_sr_d;
  logic [6:0]      crc_q, crc_d;
  logic [1:0]      type_q, type_d;
  logic [135:0]    resp_q, resp_d;
  logic            timeout_q, timeout_d;
  logic            crc_err_q, crc_err_d;
  logic            done_q, done_d;

  logic            tick;
  logic            tx_bit;
  logic            rx_bit;
  logic [135:0]    resp_shift;
  logic [CntW-1:0] rx_last;
  logic            rx_err;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign tick       = (state_q != StIdle) && (div_q == DivW'(CLK_DIV - 1));
  assign rx_bit     = bus.sd_cmd_i;
  assign resp_shift = {resp_q[134:0], rx_bit};
  assign rx_last    = (type_q == 2'b11) ? CntW'(135) : CntW'(47);

  // Frame bits 47..8 come from the shifter, then the live CRC register, then the end bit.
  assign tx_bit = (cnt_q < CntW'(40)) ? tx_sr_q[39] :
                  (cnt_q < CntW'(47)) ? crc_q[6]    : 1'b1;

  // Evaluated on the final response bit, where resp_shift holds the full frame.
  assign rx_err = !rx_bit ||
                  ((type_q == 2'b11) ? resp_shift[134] : resp_shift[46]) ||
                  ((type_q == 2'b01) && (resp_shift[7:1] != crc_q));

  always_comb begin
    state_d   = state_q;
    div_d     = '0;
    cnt_d     = cnt_q;
    tx_sr_d   = tx_sr_q;
    crc_d     = crc_q;
    type_d    = type_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    crc_err_d = crc_err_q;
    done_d    = 1'b0;
    if (state_q != StIdle) div_d = tick ? '0 : div_q + DivW'(1);

    unique case (state_q)
      StIdle: begin
        if (bus.send_en) begin
          tx_sr_d   = {1'b0, 1'b1, bus.cmd_index, bus.cmd_arg};
          type_d    = bus.resp_type;
          resp_d    = '0;
          timeout_d = 1'b0;
          crc_err_d = 1'b0;
          crc_d     = '0;
          cnt_d     = '0;
          state_d   = StTx;
        end
      end
      StTx: begin
        if (tick) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q < CntW'(40)) begin
            crc_d   = crc7_step(crc_q, tx_sr_q[39]);
            tx_sr_d = {tx_sr_q[38:0], 1'b0};
          end else if (cnt_q < CntW'(47)) begin
            crc_d = {crc_q[5:0], 1'b0};
          end else begin
            cnt_d = '0;
            crc_d = '0;
            if (type_q == 2'b00) begin
              done_d  = 1'b1;
              state_d = StGap;
            end else begin
              state_d = StWait;
            end
          end
        end
      end
      StWait: begin
        if (tick) begin
          cnt_d = cnt_q + CntW'(1);
          if ((cnt_q >= CntW'(2)) && !rx_bit) begin
            resp_d  = resp_shift;
            cnt_d   = CntW'(1);
            state_d = StRx;
          end else if (cnt_q == CntW'(NCR_MAX - 1)) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            cnt_d     = '0;
            state_d   = StGap;
          end
        end
      end
      StRx: begin
        if (tick) begin
          resp_d = resp_shift;
          cnt_d  = cnt_q + CntW'(1);
          if ((type_q == 2'b01) && (cnt_q < CntW'(40))) crc_d = crc7_step(crc_q, rx_bit);
          if (cnt_q == rx_last) begin
            crc_err_d = rx_err;
            done_d    = 1'b1;
            cnt_d     = '0;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (tick) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(NCC_MIN - 1)) begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      cnt_q     <= '0;
      tx_sr_q   <= '0;
      crc_q     <= '0;
      type_q    <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tx_sr_q   <= tx_sr_d;
      crc_q     <= crc_d;
      type_q    <= type_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      crc_err_q <= crc_err_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready     = (state_q == StIdle);
  assign bus.sd_cmd_oe = (state_q == StTx);
  assign bus.sd_cmd_o  = (state_q == StTx) ? tx_bit : 1'b1;
  assign bus.bit_tick  = tick;
  assign bus.resp      = resp_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;
  assign bus.crc_err   = crc_err_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Scoreboard bench for sd_cmd_engine: expected frames and results are queued at issue
// and compared when the serialised frame completes or done pulses.
module tb_sd_cmd_engine;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned NCR_MAX = 64;
  localparam int unsigned NCC_MIN = 8;

  typedef struct packed {
    logic [135:0] resp;
    logic         timeout;
    logic         crc_err;
  } result_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  logic [47:0] frame_q[$];
  result_t     result_q[$];

  sd_cmd_engine_if bus ();

  sd_cmd_engine #(
    .CLK_DIV(CLK_DIV),
    .NCR_MAX(NCR_MAX),
    .NCC_MIN(NCC_MIN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] d;
    logic [6:0]  c;
    logic        fb;
    d = {2'b01, idx, arg};
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return {d, c, 1'b1};
  endfunction

  // Frame monitor: one bit per period, sampled on the last clk of the period.
  logic [47:0] mon_sr = '0;
  logic [47:0] mon_exp;
  int          mon_n = 0;
  always @(negedge clk) begin
    if (reset || !bus.sd_cmd_oe) begin
      mon_n = 0;
    end else if (bus.bit_tick) begin
      mon_sr = {mon_sr[46:0], bus.sd_cmd_o};
      mon_n++;
      if (mon_n == 48) begin
        mon_n = 0;
        checks++;
        if (frame_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected: got %h, required no frame", mon_sr);
        end else begin
          mon_exp = frame_q.pop_front();
          if (mon_sr !== mon_exp) begin
            errors++;
            $display("FAIL frame: got %h, required %h", mon_sr, mon_exp);
          end
        end
      end
    end
  end

  // Result monitor: pops one expected result per done pulse.
  result_t res_got, res_exp;
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      done_cnt++;
      checks++;
      res_got = '{resp: bus.resp, timeout: bus.timeout, crc_err: bus.crc_err};
      if (result_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got resp=%h to=%b ce=%b, required no done",
                 res_got.resp, res_got.timeout, res_got.crc_err);
      end else begin
        res_exp = result_q.pop_front();
        if (res_got !== res_exp) begin
          errors++;
          $display("FAIL result: got resp=%h to=%b ce=%b, required resp=%h to=%b ce=%b",
                   res_got.resp, res_got.timeout, res_got.crc_err,
                   res_exp.resp, res_exp.timeout, res_exp.crc_err);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ);
    int n = 0;
    @(negedge clk);
    while (!bus.ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL issue_ready: got ready=0, required ready=1");
    end
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    bus.resp_type = typ;
    bus.send_en   = 1'b1;
    @(negedge clk);
    bus.send_en = 1'b0;
  endtask

  task automatic wait_done(input int start, input int limit);
    int n = 0;
    while (done_cnt == start && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_cnt == start) begin
      errors++;
      $display("FAIL wait_done: got no done in %0d cycles, required done", limit);
    end
  endtask

  // Card model: holds the line high for `delay` periods, then sends `len` bits MSB first.
  task automatic card_reply(input int delay, input logic [135:0] bits, input int len);
    int sent = 0;
    int ticks = 0;
    int guard = 0;
    while (bus.sd_cmd_oe && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    guard = 0;
    while (sent <= len && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (bus.bit_tick) begin
        @(posedge clk);
        #1;
        ticks++;
        if (ticks >= delay) begin
          bus.sd_cmd_i = (sent < len) ? bits[len-1-sent] : 1'b1;
          sent++;
        end
      end
    end
    bus.sd_cmd_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] got, req;
    @(negedge clk);
    got = {bus.ready, bus.sd_cmd_o, bus.sd_cmd_oe, bus.bit_tick, bus.done, bus.timeout,
           bus.crc_err, |bus.resp};
    req = 8'b1100_0000;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== req[i]) begin
        errors++;
        $display("FAIL reset_bit%0d: got %b, required %b", i, got[i], req[i]);
      end
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmd0_timing();
    int oe_cnt = 0;
    int done_k = -1;
    int ready_k = -1;
    frame_q.push_back(48'h400000000095);
    result_q.push_back('0);
    issue(6'd0, 32'd0, 2'b00);
    for (int k = 1; k <= 130; k++) begin
      if (bus.sd_cmd_oe) oe_cnt++;
      if (bus.done && done_k < 0) done_k = k;
      if (bus.ready && ready_k < 0) ready_k = k;
      @(negedge clk);
    end
    checks++;
    if (oe_cnt !== 96) begin
      errors++;
      $display("FAIL cmd0_oe_cycles: got %0d, required 96", oe_cnt);
    end
    checks++;
    if (done_k !== 97) begin
      errors++;
      $display("FAIL cmd0_done_cycle: got %0d, required 97", done_k);
    end
    checks++;
    if (ready_k !== 113) begin
      errors++;
      $display("FAIL cmd0_ready_cycle: got %0d, required 113", ready_k);
    end
  endtask

  task automatic test_cmd8(input logic [47:0] reply, input logic exp_err);
    int d0;
    frame_q.push_back(48'h48000001AA87);
    result_q.push_back('{resp: {88'd0, reply}, timeout: 1'b0, crc_err: exp_err});
    d0 = done_cnt;
    issue(6'd8, 32'h1AA, 2'b01);
    card_reply(4, {88'd0, reply}, 48);
    wait_done(d0, 400);
    repeat (6) @(negedge clk);
    checks++;
    if (bus.resp !== {88'd0, reply} || bus.crc_err !== exp_err) begin
      errors++;
      $display("FAIL cmd8_hold: got resp=%h ce=%b, required resp=%h ce=%b",
               bus.resp, bus.crc_err, reply, exp_err);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL cmd8_done_count: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    frame_q.push_back(48'h510000000055);
    result_q.push_back('{resp: '0, timeout: 1'b1, crc_err: 1'b0});
    issue(6'd17, 32'd0, 2'b01);
    wait_done(d0, 600);
  endtask

  task automatic test_long(input logic [135:0] reply, input logic exp_err);
    int d0 = done_cnt;
    frame_q.push_back(48'h42000000004D);
    result_q.push_back('{resp: reply, timeout: 1'b0, crc_err: exp_err});
    issue(6'd2, 32'd0, 2'b11);
    card_reply(2, reply, 136);
    wait_done(d0, 800);
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    logic [3:0] got;
    issue(6'd17, 32'h1234_5678, 2'b01);
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    got = {bus.sd_cmd_oe, bus.sd_cmd_o, bus.ready, bus.bit_tick};
    checks++;
    if (got !== 4'b0110) begin
      errors++;
      $display("FAIL reset_mid: got oe,o,ready,tick=%b, required 0110", got);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_quiet: got done_delta=%0d ready=%b, required 0 and 1",
               done_cnt - d0, bus.ready);
    end
  endtask

  task automatic test_ignore();
    int d0 = done_cnt;
    frame_q.push_back(48'h400000000095);
    result_q.push_back('0);
    issue(6'd0, 32'd0, 2'b00);
    repeat (10) @(negedge clk);
    bus.cmd_index = 6'd5;
    bus.cmd_arg   = 32'hDEAD_BEEF;
    bus.send_en   = 1'b1;
    @(negedge clk);
    bus.send_en = 1'b0;
    wait_done(d0, 300);
    repeat (3) @(negedge clk);
    bus.send_en = 1'b1;
    @(negedge clk);
    bus.send_en = 1'b0;
    repeat (150) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore: got done_delta=%0d ready=%b, required 1 and 1",
               done_cnt - d0, bus.ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ia, ib;
    logic [31:0] aa, ab;
    int          n;
    int          d0;
    for (int it = 0; it < 2; it++) begin
      ia = 6'($urandom_range(0, 63));
      ib = 6'($urandom_range(0, 63));
      aa = $urandom;
      ab = $urandom;
      frame_q.push_back(make_frame(ia, aa));
      frame_q.push_back(make_frame(ib, ab));
      result_q.push_back('0);
      result_q.push_back('0);
      issue(ia, aa, 2'b00);
      repeat (4) @(negedge clk);
      bus.cmd_index = ib;
      bus.cmd_arg   = ab;
      bus.send_en   = 1'b1;
      n = 0;
      while (!bus.ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
      bus.send_en = 1'b0;
      checks++;
      if (bus.sd_cmd_oe !== 1'b1 || bus.ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_accept: got oe=%b ready=%b, required oe=1 ready=0",
                 bus.sd_cmd_oe, bus.ready);
      end
      d0 = done_cnt;
      wait_done(d0, 300);
      repeat (40) @(negedge clk);
    end
  endtask

  initial begin
    bus.send_en   = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg   = '0;
    bus.resp_type = '0;
    bus.sd_cmd_i  = 1'b1;
    test_reset();
    test_cmd0_timing();
    test_cmd8(48'h08000001AA13, 1'b0);
    test_cmd8(48'h08000001AA01, 1'b1);
    test_timeout();
    test_long(136'h3F0123456789ABCDEF0123456789ABCDFE, 1'b1);
    test_long(136'h3F0123456789ABCDEF0123456789ABCDFF, 1'b0);
    test_reset_mid();
    test_ignore();
    test_back_to_back();
    repeat (20) @(negedge clk);
    checks++;
    if (frame_q.size() != 0 || result_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got frames=%0d results=%0d, required 0 and 0",
               frame_q.size(), result_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
